// File: rtl/dsp_pkg.sv
// Shared constants for the DSP post-adder/accumulator: opmode field positions,
// X/Z operand select encodings and datapath widths.
package dsp_pkg;

  localparam int unsigned P_W = 48;
  localparam int unsigned M_W = 36;

  localparam int unsigned OPM_X_LSB = 0;
  localparam int unsigned OPM_Z_LSB = 2;
  localparam int unsigned OPM_CIN   = 5;
  localparam int unsigned OPM_SUB   = 7;

  typedef enum logic [1:0] {
    X_ZERO = 2'b00,
    X_M    = 2'b01,
    X_P    = 2'b10,
    X_DAB  = 2'b11
  } x_sel_e;

  typedef enum logic [1:0] {
    Z_ZERO = 2'b00,
    Z_PCIN = 2'b01,
    Z_P    = 2'b10,
    Z_C    = 2'b11
  } z_sel_e;

endpackage

// File: rtl/pipe_reg_async.sv
// Optional pipeline register: async active-low clear, clock enable, and a
// PRESENT=0 mode that turns it into a plain wire.
module pipe_reg_async #(
  parameter int unsigned WIDTH   = 1,
  parameter bit          PRESENT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (PRESENT) begin : g_reg
      logic [WIDTH-1:0] q_r;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q_r <= '0;
        end else if (ce) begin
          q_r <= d;
        end
      end

      assign q = q_r;
    end else begin : g_bypass
      logic unused_ctrl;
      assign unused_ctrl = &{1'b0, clk, rst_n, ce};
      assign q = d;
    end
  endgenerate

endmodule

// File: rtl/dsp_post_adder_accum.sv
// DSP post-adder / accumulator: X/Z operand muxes, add or subtract with carry-in,
// and optional opmode, carry-in, P and carry-out registers.
module dsp_post_adder_accum
  import dsp_pkg::*;
#(
  parameter int    PREG        = 1,
  parameter int    CARRYINREG  = 1,
  parameter int    CARRYOUTREG = 1,
  parameter int    OPMODEREG   = 1,
  parameter string CARRYINSEL  = "OPMODE5"
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ce_p,
  input  logic           ce_carry,
  input  logic           ce_opmode,
  input  logic [7:0]     opmode,
  input  logic [M_W-1:0] m,
  input  logic [P_W-1:0] dab,
  input  logic [P_W-1:0] c,
  input  logic [P_W-1:0] pcin,
  input  logic           carryin,
  output logic [P_W-1:0] p,
  output logic [P_W-1:0] pcout,
  output logic           carryout,
  output logic           carryoutf
);

  localparam bit CIN_OPM  = (CARRYINSEL == "OPMODE5");
  localparam bit CIN_PORT = (CARRYINSEL == "CARRYIN");

  logic [7:0]     opmode_q;
  logic           cin_d;
  logic           cin;
  logic [P_W-1:0] p_q;
  logic [P_W-1:0] p_fb;
  logic [P_W-1:0] x_mux;
  logic [P_W-1:0] z_mux;
  logic [P_W:0]   sum;
  logic           co_q;
  logic           unused_bits;

  assign unused_bits = &{1'b0, opmode[6], opmode[4], opmode_q[6:4]};

  pipe_reg_async #(.WIDTH(8), .PRESENT(OPMODEREG != 0)) u_opmode_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (ce_opmode),
    .d     (opmode),
    .q     (opmode_q)
  );

  // An unrecognised CARRYINSEL leaves both selects false, so cin is tied to 0.
  assign cin_d = (CIN_OPM & opmode[OPM_CIN]) | (CIN_PORT & carryin);

  pipe_reg_async #(.WIDTH(1), .PRESENT(CARRYINREG != 0)) u_carryin_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (ce_carry),
    .d     (cin_d),
    .q     (cin)
  );

  // Without a P register the feedback path is tied off to avoid a loop.
  generate
    if (PREG != 0) begin : g_fb
      assign p_fb = p_q;
    end else begin : g_no_fb
      assign p_fb = '0;
    end
  endgenerate

  always_comb begin
    x_mux = '0;
    case (x_sel_e'(opmode_q[OPM_X_LSB +: 2]))
      X_ZERO:  x_mux = '0;
      X_M:     x_mux = {{(P_W-M_W){1'b0}}, m};
      X_P:     x_mux = p_fb;
      X_DAB:   x_mux = dab;
      default: x_mux = '0;
    endcase
  end

  always_comb begin
    z_mux = '0;
    case (z_sel_e'(opmode_q[OPM_Z_LSB +: 2]))
      Z_ZERO:  z_mux = '0;
      Z_PCIN:  z_mux = pcin;
      Z_P:     z_mux = p_fb;
      Z_C:     z_mux = c;
      default: z_mux = '0;
    endcase
  end

  always_comb begin
    sum = '0;
    if (opmode_q[OPM_SUB]) begin
      sum = {1'b0, z_mux} - ({1'b0, x_mux} + {{P_W{1'b0}}, cin});
    end else begin
      sum = {1'b0, z_mux} + {1'b0, x_mux} + {{P_W{1'b0}}, cin};
    end
  end

  pipe_reg_async #(.WIDTH(P_W), .PRESENT(PREG != 0)) u_p_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (ce_p),
    .d     (sum[P_W-1:0]),
    .q     (p_q)
  );

  pipe_reg_async #(.WIDTH(1), .PRESENT(CARRYOUTREG != 0)) u_carryout_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (ce_p),
    .d     (sum[P_W]),
    .q     (co_q)
  );

  assign p         = p_q;
  assign pcout     = p_q;
  assign carryout  = co_q;
  assign carryoutf = co_q;

endmodule

// File: tb/tb_dsp_post_adder_accum.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// cycle-level arithmetic model, for registered, CARRYIN-sourced and bypassed builds.
module tb_dsp_post_adder_accum;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ce_p, ce_carry, ce_opmode;
  logic [7:0]  opmode;
  logic [35:0] m;
  logic [47:0] dab, c, pcin;
  logic        carryin;

  logic [47:0] p0, pc0, p1, pc1, p2, pc2;
  logic        co0, cof0, co1, cof1, co2, cof2;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  // Reference state: index 0 = default build, 1 = CARRYIN build
  logic [47:0] mp  [2];
  logic        mco [2];
  logic        mcin[2];
  logic [7:0]  mop;

  always #5 clk = ~clk;

  dsp_post_adder_accum dut (
    .clk(clk), .rst_n(rst_n), .ce_p(ce_p), .ce_carry(ce_carry), .ce_opmode(ce_opmode),
    .opmode(opmode), .m(m), .dab(dab), .c(c), .pcin(pcin), .carryin(carryin),
    .p(p0), .pcout(pc0), .carryout(co0), .carryoutf(cof0)
  );

  dsp_post_adder_accum #(.CARRYINSEL("CARRYIN")) dut_ci (
    .clk(clk), .rst_n(rst_n), .ce_p(ce_p), .ce_carry(ce_carry), .ce_opmode(ce_opmode),
    .opmode(opmode), .m(m), .dab(dab), .c(c), .pcin(pcin), .carryin(carryin),
    .p(p1), .pcout(pc1), .carryout(co1), .carryoutf(cof1)
  );

  dsp_post_adder_accum #(.PREG(0), .CARRYINREG(0), .CARRYOUTREG(0), .OPMODEREG(0)) dut_comb (
    .clk(clk), .rst_n(rst_n), .ce_p(ce_p), .ce_carry(ce_carry), .ce_opmode(ce_opmode),
    .opmode(opmode), .m(m), .dab(dab), .c(c), .pcin(pcin), .carryin(carryin),
    .p(p2), .pcout(pc2), .carryout(co2), .carryoutf(cof2)
  );

  function automatic logic [48:0] alu(input logic [7:0] op, input logic ci, input logic [47:0] fb);
    logic [48:0] x, z;
    case (op[1:0])
      2'd0:    x = 49'd0;
      2'd1:    x = {13'd0, m};
      2'd2:    x = {1'b0, fb};
      default: x = {1'b0, dab};
    endcase
    case (op[3:2])
      2'd0:    z = 49'd0;
      2'd1:    z = {1'b0, pcin};
      2'd2:    z = {1'b0, fb};
      default: z = {1'b0, c};
    endcase
    return op[7] ? (z - x - {48'd0, ci}) : (z + x + {48'd0, ci});
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mp[i] = '0; mco[i] = 1'b0; mcin[i] = 1'b0;
    end
    mop = '0;
  endtask

  // Advance one rising edge; the model samples the same inputs the DUTs see.
  task automatic tick();
    logic [48:0] r[2];
    logic        src[2];
    src[0] = opmode[5];
    src[1] = carryin;
    for (int i = 0; i < 2; i++) r[i] = alu(mop, mcin[i], mp[i]);
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (ce_p) begin
        mp[i]  = r[i][47:0];
        mco[i] = r[i][48];
      end
      if (ce_carry) mcin[i] = src[i];
    end
    if (ce_opmode) mop = opmode;
  endtask

  task automatic check_all();
    logic [48:0] rc;
    rc = alu(opmode, opmode[5], 48'd0);
    chk("dut.p",        p0,   mp[0]);
    chk("dut.pcout",    pc0,  mp[0]);
    chk("dut.co",       co0,  mco[0]);
    chk("dut.cof",      cof0, mco[0]);
    chk("ci.p",         p1,   mp[1]);
    chk("ci.pcout",     pc1,  mp[1]);
    chk("ci.co",        co1,  mco[1]);
    chk("ci.cof",       cof1, mco[1]);
    chk("comb.p",       p2,   rc[47:0]);
    chk("comb.pcout",   pc2,  rc[47:0]);
    chk("comb.co",      co2,  rc[48]);
    chk("comb.cof",     cof2, rc[48]);
  endtask

  initial begin
    rst_n = 1'b0; ce_p = 1'b1; ce_carry = 1'b1; ce_opmode = 1'b1;
    opmode = 8'h00; m = '0; dab = '0; c = '0; pcin = '0; carryin = 1'b0;
    model_reset();

    // Reset state
    #2;
    chk("rst.p",    p0,   48'd0);
    chk("rst.pc",   pc0,  48'd0);
    chk("rst.co",   co0,  1'b0);
    chk("rst.cof",  cof0, 1'b0);
    #10;
    rst_n = 1'b1;

    // X=m, Z=c: 5 + 10
    opmode = 8'h0D; m = 36'd5; c = 48'd10;
    tick(); tick();
    chk("add.p", p0, 48'd15);
    check_all();

    // Subtract with borrow: 3 - 5
    opmode = 8'h8F; c = 48'd3; dab = 48'd5;
    tick(); tick();
    chk("sub.p",  p0,  48'hFFFF_FFFF_FFFE);
    chk("sub.co", co0, 1'b1);
    check_all();

    // Accumulate m=1 from reset, then hold with ce_p=0
    rst_n = 1'b0; model_reset(); #1; rst_n = 1'b1;
    opmode = 8'h09; m = 36'd1; ce_p = 1'b0;
    tick();
    ce_p = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("acc.p", p0, 48'(k));
    end
    ce_p = 1'b0;
    tick(); tick();
    chk("hold.p", p0, 48'd4);
    check_all();

    // Preload all-ones, then accumulate m=2 to wrap
    ce_p = 1'b1; opmode = 8'h0F; c = 48'hFFFF_FFFF_FFFF; dab = '0;
    tick(); tick();
    chk("preload.p", p0, 48'hFFFF_FFFF_FFFF);
    opmode = 8'h09; m = 36'd2;
    tick(); tick();
    chk("wrap.p",  p0,  48'd1);
    chk("wrap.co", co0, 1'b1);
    check_all();

    // Asynchronous reset between edges, with every clock enable low
    m = 36'd1;
    tick(); tick();
    @(negedge clk);
    ce_p = 1'b0; ce_carry = 1'b0; ce_opmode = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst.p",   p0,  48'd0);
    chk("arst.pc",  pc0, 48'd0);
    chk("arst.co",  co0, 1'b0);
    model_reset();
    #1;
    rst_n = 1'b1; ce_p = 1'b1; ce_carry = 1'b1; ce_opmode = 1'b1;
    tick(); tick(); tick();
    chk("restart.p", p0, 48'd2);
    check_all();

    // External carry-in source
    carryin = 1'b1; opmode = 8'h0D; m = '0; c = 48'd7;
    tick(); tick();
    chk("cin.ci.p",  p1, 48'd8);
    chk("cin.def.p", p0, 48'd7);
    check_all();

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      opmode    = 8'($urandom);
      m         = {4'($urandom), 32'($urandom)};
      dab       = {16'($urandom), 32'($urandom)};
      c         = ($urandom_range(0, 7) == 0) ? 48'hFFFF_FFFF_FFFF : {16'($urandom), 32'($urandom)};
      pcin      = {16'($urandom), 32'($urandom)};
      carryin   = 1'($urandom);
      ce_p      = ($urandom_range(0, 3) != 0);
      ce_carry  = ($urandom_range(0, 3) != 0);
      ce_opmode = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0) begin
        rst_n = 1'b0; model_reset(); #1; rst_n = 1'b1;
      end
      tick();
      check_all();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dsp_post_adder_accum.md
DSP_POST_ADDER_ACCUM -- requirements
Module: dsp_post_adder_accum

Interface
REQ-001 The block SHALL have parameter PREG, default 1, meaning P output register present (1) or bypassed (0).
REQ-002 The block SHALL have parameter CARRYINREG, default 1, meaning carry-in register present (1) or bypassed (0).
REQ-003 The block SHALL have parameter CARRYOUTREG, default 1, meaning carry-out register present (1) or bypassed (0).
REQ-004 The block SHALL have parameter OPMODEREG, default 1, meaning opmode register present (1) or bypassed (0).
REQ-005 The block SHALL have parameter CARRYINSEL, default "OPMODE5", meaning carry-in source is opmode[5] ("OPMODE5") or port carryin ("CARRYIN").
REQ-006 The block SHALL have clk  in  1  the single clock; all state updates on its rising edge.
REQ-007 The block SHALL have rst_n  in  1  reset, asynchronous, active-low.
REQ-008 The block SHALL have ce_p, ce_carry, ce_opmode  in  1 each  clock enables for the P/carry-out, carry-in and opmode registers.
REQ-009 The block SHALL have opmode  in  8  opmode; [1:0] X select, [3:2] Z select, [5] carry-in value, [7] subtract.
REQ-010 The block SHALL have m  in  36  multiplier product, unsigned.
REQ-011 The block SHALL have dab  in  48  concatenation {d[11:0], a[17:0], b[17:0]}.
REQ-012 The block SHALL have c, pcin  in  48 each  C operand and cascade input.
REQ-013 The block SHALL have carryin  in  1  external carry-in.
REQ-014 The block SHALL have p, pcout  out  48 each  result and cascade copy, with pcout identical to p.
REQ-015 The block SHALL have carryout, carryoutf  out  1 each  carry-out and fabric copy, with carryoutf identical to carryout.

Function
REQ-016 X mux SHALL select 0 for opmode[1:0]=00, {12'b0,m} for 01, P feedback for 10, and dab for 11.
REQ-017 Z mux SHALL select 0 for opmode[3:2]=00, pcin for 01, P feedback for 10, and c for 11.
REQ-018 P feedback SHALL be the P register content when PREG=1, and SHALL be constant 0 when PREG=0, so that no combinational loop exists.
REQ-019 With opmode[7]=0 the result SHALL be the 49-bit Z + X + cin; with opmode[7]=1 it SHALL be the 49-bit Z - (X + cin).
REQ-020 p SHALL equal result[47:0], and carryout SHALL equal result[48], which acts as the borrow indicator in subtract mode.
REQ-021 Arithmetic SHALL wrap modulo 2^48, and no saturation SHALL occur.
REQ-022 cin SHALL be opmode[5] or carryin per CARRYINSEL, registered when CARRYINREG=1 and combinational otherwise.
REQ-023 Opmode SHALL be registered when OPMODEREG=1 and combinational otherwise.
REQ-024 Latency from operand to p SHALL be PREG cycles, and from opmode or carry source SHALL additionally include OPMODEREG or CARRYINREG cycles.
REQ-025 Each register SHALL load only when its clock enable is 1 and SHALL hold otherwise.
REQ-026 Accumulate (X=m, Z=P, ce_p=1) SHALL add m every cycle.
REQ-027 Accumulate SHALL wrap from 2^48-1 to the low bits of the sum and set carryout for that cycle.
REQ-028 An illegal CARRYINSEL value SHALL force cin=0.

Reset
REQ-029 rst_n=0 SHALL clear the P, carry-out, carry-in and opmode registers immediately, independent of clk and of every clock enable.
REQ-030 While rst_n=0, p=0, pcout=0, carryout=0 and carryoutf=0 whenever the respective register is present.
REQ-031 Reset asserted mid-accumulation SHALL discard the running sum, and the first edge after deassertion SHALL compute from a P feedback value of 0.
REQ-032 Reset SHALL take priority over clock enables.

Structure
REQ-033 Package dsp_pkg SHALL hold the opmode field bit-position constants, the X/Z select encodings and the 48-bit/36-bit width constants.
REQ-034 One sub-module, pipe_reg_async (parameterised width, bypass select, async active-low reset, clock enable), SHALL implement every optional register.

Verification
REQ-035 The bench SHALL check: defaults, opmode=8'h0D (X=m, Z=c), m=5, c=10 -> p=15 one cycle after opmode is registered.
REQ-036 The bench SHALL check: opmode=8'h8F (subtract, X=dab, Z=c), c=3, dab=5 -> p=48'hFFFF_FFFF_FFFE, carryout=1.
REQ-037 The bench SHALL check: accumulate opmode=8'h09, m=1 for 4 cycles from reset -> p=1,2,3,4; then ce_p=0 -> p holds 4.
REQ-038 The bench SHALL check: P preloaded to 48'hFFFF_FFFF_FFFF, accumulate m=2 -> p=1, carryout=1.
REQ-039 The bench SHALL check: rst_n pulsed low between clock edges during accumulation -> p=0 and carryout=0 immediately, and accumulation restarts from 0.
REQ-040 The bench SHALL check: CARRYINSEL="CARRYIN", carryin=1, opmode=8'h0D, m=0, c=7 -> p=8 after the CARRYINREG plus PREG cycles.
